alu_arbiter: RTL and testbench

//  Shares one 8-bit registered ALU (one posedge-sampled result stage, ops 0-7: ADD,SUB,NOT,NAND,NOR,AND,OR,XOR)

---
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one registered 8-bit ALU among
//               NUM_REQ requesters, with id-tagged in-order responses.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_en,
    input  logic [NUM_REQ-1:0]     in_req_valid,
    input  logic [8*NUM_REQ-1:0]   in_req_a,
    input  logic [8*NUM_REQ-1:0]   in_req_b,
    input  logic [3*NUM_REQ-1:0]   in_req_op,
    output logic [NUM_REQ-1:0]     out_req_ready,
    output logic [7:0]             out_alu_a,
    output logic [7:0]             out_alu_b,
    output logic [2:0]             out_alu_op,
    input  logic [7:0]             in_alu_data,
    output logic                   out_rsp_valid,
    output logic [ID_W-1:0]        out_rsp_id,
    output logic [7:0]             out_rsp_data,
    output logic                   out_busy
);

    localparam logic [ID_W-1:0] c_PTR_RST = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] r_ptr;
    logic            w_gnt_vld;
    logic [ID_W-1:0] w_gnt_id;
    logic [7:0]      w_sel_a;
    logic [7:0]      w_sel_b;
    logic [2:0]      w_sel_op;
    logic            w_busy_nxt;

    logic [7:0]      r_alu_a;
    logic [7:0]      r_alu_b;
    logic [2:0]      r_alu_op;
    logic [ALU_LAT:0] r_stg_vld;
    logic [ID_W-1:0] r_stg_id [ALU_LAT:0];
    logic            r_rsp_valid;
    logic [ID_W-1:0] r_rsp_id;
    logic [7:0]      r_rsp_data;
    logic            r_busy;

    // First valid requester strictly after the last granted one wins.
    always_comb begin
        logic [ID_W-1:0] v_idx;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        v_idx     = '0;
        if (in_en) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                v_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
                if (!w_gnt_vld && in_req_valid[v_idx]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_id  = v_idx;
                end
            end
        end
    end

    always_comb begin
        out_req_ready = '0;
        w_sel_a       = '0;
        w_sel_b       = '0;
        w_sel_op      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_vld && (w_gnt_id == ID_W'(i))) begin
                out_req_ready[i] = 1'b1;
                w_sel_a          = in_req_a[8*i +: 8];
                w_sel_b          = in_req_b[8*i +: 8];
                w_sel_op         = in_req_op[3*i +: 3];
            end
        end
    end

    // Busy is registered: next value covers every stage that will hold an op.
    always_comb begin
        w_busy_nxt = w_gnt_vld;
        for (int k = 0; k < ALU_LAT; k++) begin
            w_busy_nxt = w_busy_nxt | r_stg_vld[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr        <= c_PTR_RST;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_stg_vld[0] <= 1'b0;
            r_stg_id[0]  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_alu_a      <= w_sel_a;
            r_alu_b      <= w_sel_b;
            r_alu_op     <= w_sel_op;
            r_stg_vld[0] <= w_gnt_vld;
            r_stg_id[0]  <= w_gnt_id;
            r_busy       <= w_busy_nxt;
            if (w_gnt_vld) begin
                r_ptr <= w_gnt_id;
            end
        end
    end

    generate
        for (genvar k = 1; k <= ALU_LAT; k++) begin : g_stage
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_stg_vld[k] <= 1'b0;
                    r_stg_id[k]  <= '0;
                end else begin
                    r_stg_vld[k] <= r_stg_vld[k-1];
                    r_stg_id[k]  <= r_stg_id[k-1];
                end
            end
        end
    endgenerate

    // Response data/id only move on a valid retire so they hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= r_stg_vld[ALU_LAT];
            if (r_stg_vld[ALU_LAT]) begin
                r_rsp_id   <= r_stg_id[ALU_LAT];
                r_rsp_data <= in_alu_data;
            end
        end
    end

    assign out_alu_a     = r_alu_a;
    assign out_alu_b     = r_alu_b;
    assign out_alu_op    = r_alu_op;
    assign out_rsp_valid = r_rsp_valid;
    assign out_rsp_id    = r_rsp_id;
    assign out_rsp_data  = r_rsp_data;
    assign out_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed plus random bench for alu_arbiter against a
//               queue-based reference model and a behavioural registered ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LAT = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_en;
    logic [N-1:0]   vld;
    logic [8*N-1:0] a_bus;
    logic [8*N-1:0] b_bus;
    logic [3*N-1:0] op_bus;
    logic [N-1:0]   ready;
    logic [7:0]     alu_a;
    logic [7:0]     alu_b;
    logic [2:0]     alu_op;
    logic [7:0]     alu_q;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [7:0]     rsp_data;
    logic           busy;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .ID_W(IDW), .ALU_LAT(LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_en         (in_en),
        .in_req_valid  (vld),
        .in_req_a      (a_bus),
        .in_req_b      (b_bus),
        .in_req_op     (op_bus),
        .out_req_ready (ready),
        .out_alu_a     (alu_a),
        .out_alu_b     (alu_b),
        .out_alu_op    (alu_op),
        .in_alu_data   (alu_q),
        .out_rsp_valid (rsp_valid),
        .out_rsp_id    (rsp_id),
        .out_rsp_data  (rsp_data),
        .out_busy      (busy)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        case (op)
            3'd0:    return 8'(a + b);
            3'd1:    return 8'(a - b);
            3'd2:    return ~a;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a & b;
            3'd6:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Single-stage registered ALU
    always_ff @(posedge clk) alu_q <= alu_f(alu_a, alu_b, alu_op);

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } rsp_t;

    rsp_t       q[$];
    int         m_ptr;
    int         cyc;
    int         m_last_id;
    logic [7:0] m_last_data;
    int         last_g;
    int         total;
    int         bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int model_grant();
        int i;
        if (!in_en) return -1;
        for (int k = 1; k <= N; k++) begin
            i = (m_ptr + k) % N;
            if (vld[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op);
        vld[i]          = 1'b1;
        a_bus[8*i +: 8] = a;
        b_bus[8*i +: 8] = b;
        op_bus[3*i +: 3] = op;
    endtask

    // One clock: check grant before the edge, then advance the model and check outputs.
    task automatic cycle();
        int         g;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [2:0] eop;
        logic       ev;
        #1;
        g = -1;
        if (rst_n) begin
            g = model_grant();
            chk("ready", 32'(ready), (g >= 0) ? (32'(1) << g) : 32'(0));
        end
        ea = 8'h00; eb = 8'h00; eop = 3'd0;
        if (g >= 0) begin
            ea  = a_bus[8*g +: 8];
            eb  = b_bus[8*g +: 8];
            eop = op_bus[3*g +: 3];
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            q.delete();
            m_ptr       = N - 1;
            m_last_id   = 0;
            m_last_data = 8'h00;
        end else if (g >= 0) begin
            q.push_back('{cyc + LAT + 1, g, alu_f(ea, eb, eop)});
            m_ptr = g;
        end
        ev = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev          = 1'b1;
            m_last_id   = q[0].id;
            m_last_data = q[0].data;
            void'(q.pop_front());
        end
        chk("alu_a", 32'(alu_a), 32'(ea));
        chk("alu_b", 32'(alu_b), 32'(eb));
        chk("alu_op", 32'(alu_op), 32'(eop));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("rsp_id", 32'(rsp_id), 32'(m_last_id));
        chk("rsp_data", 32'(rsp_data), 32'(m_last_data));
        chk("busy", 32'(busy), (q.size() != 0) ? 32'(1) : 32'(0));
        last_g = g;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        m_ptr = N - 1; m_last_id = 0; m_last_data = 8'h00; last_g = -1;
        rst_n = 1'b0; in_en = 1'b1; vld = '0;
        a_bus = '0; b_bus = '0; op_bus = '0;
        repeat (2) cycle();
        rst_n = 1'b1;

        // Single ADD from requester 0
        set_req(0, 8'h05, 8'h03, 3'd0);
        cycle();
        vld = '0;
        repeat (4) cycle();

        // All four valid from a fresh pointer: 0,1,2,3,0,1
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom), 3'($urandom));
        repeat (6) cycle();
        vld = '0;
        repeat (3) cycle();

        // SUB underflow, NOT, XOR
        set_req(2, 8'h00, 8'h01, 3'd1); cycle(); vld = '0;
        set_req(1, 8'h0F, 8'h00, 3'd2); cycle(); vld = '0;
        set_req(3, 8'hAA, 8'hFF, 3'd7); cycle(); vld = '0;
        repeat (3) cycle();

        // Grants disabled while ops are in flight
        set_req(0, 8'h11, 8'h22, 3'd6);
        set_req(1, 8'h33, 8'h0F, 3'd3);
        repeat (2) cycle();
        in_en = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom), 3'($urandom));
        repeat (4) cycle();
        in_en = 1'b1; vld = '0;
        cycle();

        // Reset with two ops in flight, then check the pointer restarted
        set_req(2, 8'h40, 8'h02, 3'd0);
        set_req(3, 8'h7F, 8'h80, 3'd4);
        repeat (2) cycle();
        vld = '0;
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        repeat (3) cycle();
        for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom), 3'($urandom));
        cycle();
        vld = '0;
        repeat (3) cycle();

        // Lone requester 1 wins every cycle
        set_req(1, 8'hC3, 8'h3C, 3'd5);
        repeat (4) cycle();
        vld = '0;
        repeat (3) cycle();

        // Random traffic honouring the hold-until-accepted contract
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i] || last_g == i) begin
                    vld[i]           = 1'($urandom_range(0, 1));
                    a_bus[8*i +: 8]  = 8'($urandom);
                    b_bus[8*i +: 8]  = 8'($urandom);
                    op_bus[3*i +: 3] = 3'($urandom);
                end else if ($urandom_range(0, 9) == 0) begin
                    vld[i] = 1'b0;
                end
            end
            in_en = ($urandom_range(0, 7) != 0);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        rst_n = 1'b1; in_en = 1'b1; vld = '0;
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
